// File: rtl/uart_word_responder.sv
// uart_word_responder: serves a 4-byte UART address query with a 32-bit memory word sent back as 4 bytes.
// Define UART_RESP_TIMEOUT_EN to discard partial queries after TIMEOUT_BITS idle bit-times.
module uart_word_responder #(
   parameter int CLKS_PER_BIT = 868,
   parameter int ADDR_W       = 16,
   parameter int TIMEOUT_BITS = 40
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rx,
   output logic              tx,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd,
   input  logic [31:0]       mem_rdata,
   output logic              busy,
   output logic              frame_err
);
   localparam int CW = $clog2(CLKS_PER_BIT);
   typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
   typedef enum logic [2:0] {RX_ADDR, READ, CAPTURE, TX_BYTE, DONE} state_t;
   rx_state_t rstate, rstate_nx;
   state_t state, state_nx;
   logic rx_meta, rx_sync, rx_prev, byte_ok, rx_mid, rx_half, t_end, timeout;
   logic [CW-1:0] rcnt, tcnt;
   logic [2:0] rbit;
   logic [7:0] rsh;
   logic [1:0] acnt, tbyte;
   logic [23:0] abuf;
   logic [31:0] dsh;
   logic [3:0] tbit;
   assign rx_mid  = rcnt == CW'(CLKS_PER_BIT - 1);
   assign rx_half = rcnt == CW'(CLKS_PER_BIT / 2 - 1);
   assign t_end   = tcnt == CW'(CLKS_PER_BIT - 1);
   // Receiver runs in every main state so byte framing never drifts.
   always_comb begin
      rstate_nx = rstate;
      byte_ok   = 1'b0;
      frame_err = 1'b0;
      case (rstate)
         R_IDLE:  if (rx_prev && !rx_sync) rstate_nx = R_START;
         R_START: if (rx_half) rstate_nx = rx_sync ? R_IDLE : R_DATA;
         R_DATA:  if (rx_mid && rbit == 3'd7) rstate_nx = R_STOP;
         R_STOP:  if (rx_mid) begin
            rstate_nx = R_IDLE;
            byte_ok   = rx_sync;
            frame_err = !rx_sync;
         end
         default: rstate_nx = R_IDLE;
      endcase
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
         rx_prev <= 1'b1;
         rstate  <= R_IDLE;
         rcnt    <= '0;
         rbit    <= '0;
         rsh     <= '0;
      end else begin
         rx_meta <= rx;
         rx_sync <= rx_meta;
         rx_prev <= rx_sync;
         rstate  <= rstate_nx;
         rcnt    <= (rstate != rstate_nx || rx_mid) ? '0 : rcnt + 1'b1;
         if (rstate == R_DATA && rx_mid) begin
            rsh  <= {rx_sync, rsh[7:1]};
            rbit <= rbit + 1'b1;
         end
      end
   end
   always_comb begin
      state_nx = state;
      case (state)
         RX_ADDR: if (byte_ok && acnt == 2'd3) state_nx = READ;
         READ:    state_nx = CAPTURE;
         CAPTURE: state_nx = TX_BYTE;
         TX_BYTE: if (t_end && tbit == 4'd9 && tbyte == 2'd3) state_nx = DONE;
         default: state_nx = RX_ADDR;
      endcase
   end
   assign mem_rd = state == READ;
   assign tx     = state != TX_BYTE || (tbit != 4'd0 && (tbit == 4'd9 || dsh[0]));
   assign busy   = state inside {READ, CAPTURE, TX_BYTE} || (state == RX_ADDR && (acnt != 2'd0 || byte_ok));
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= RX_ADDR;
         acnt     <= '0;
         abuf     <= '0;
         mem_addr <= '0;
         dsh      <= '0;
         tcnt     <= '0;
         tbit     <= '0;
         tbyte    <= '0;
      end else begin
         state <= state_nx;
         if (frame_err || timeout) acnt <= '0;
         else if (state == RX_ADDR && byte_ok) begin
            acnt <= acnt + 1'b1;
            abuf <= {rsh, abuf[23:8]};
         end
         if (state == RX_ADDR && byte_ok && acnt == 2'd3) mem_addr <= ADDR_W'({rsh, abuf});
         if (state == CAPTURE) begin
            dsh   <= mem_rdata;
            tcnt  <= '0;
            tbit  <= '0;
            tbyte <= '0;
         end else if (state == TX_BYTE) begin
            tcnt <= t_end ? '0 : tcnt + 1'b1;
            if (t_end) begin
               tbit <= tbit == 4'd9 ? 4'd0 : tbit + 1'b1;
               if (tbit == 4'd9) tbyte <= tbyte + 1'b1;
               if (tbit != 4'd0 && tbit != 4'd9) dsh <= dsh >> 1;
            end
         end
      end
   end
`ifdef UART_RESP_TIMEOUT_EN
   localparam int TO = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TW = $clog2(TO);
   logic [TW-1:0] tmo;
   assign timeout = state == RX_ADDR && acnt != 2'd0 && rstate == R_IDLE && tmo == TW'(TO - 1);
   always_ff @(posedge clk) begin
      if (reset || state != RX_ADDR || acnt == 2'd0 || rstate != R_IDLE) tmo <= '0;
      else tmo <= tmo + 1'b1;
   end
`else
   assign timeout = 1'b0;
`endif
endmodule

// File: tb/tb_uart_word_responder.sv
// tb_uart_word_responder: directed table, corner sequences and random queries against a byte-level model.
module tb_uart_word_responder;
   localparam int CPB = 16;
   localparam int TOB = 40;
   logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
   logic tx, mem_rd, busy, frame_err;
   logic [15:0] mem_addr;
   logic [31:0] mem_rdata = '0;
   int cyc = 0, n_tests = 0, n_fail = 0;

   uart_word_responder #(.CLKS_PER_BIT(CPB), .ADDR_W(16), .TIMEOUT_BITS(TOB)) dut (
      .clk(clk), .reset(reset), .rx(rx), .tx(tx), .mem_addr(mem_addr), .mem_rd(mem_rd),
      .mem_rdata(mem_rdata), .busy(busy), .frame_err(frame_err));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_f(input logic [15:0] a);
      return a == 16'h0004 ? 32'hDEADBEEF : {a ^ 16'hC35A, a + 16'h1111};
   endfunction
   always @(posedge clk) mem_rdata <= mem_f(mem_addr);

   logic [15:0] rd_a[$];
   int rd_c[$], bf_c[$];
   int fe_cyc = 0, fe_rise = 0, b_rise = 0;
   logic busy_d = 1'b0, fe_d = 1'b0;
   always @(negedge clk) begin
      if (mem_rd) begin
         rd_a.push_back(mem_addr);
         rd_c.push_back(cyc);
      end
      if (busy_d && !busy) bf_c.push_back(cyc);
      if (!busy_d && busy) b_rise <= b_rise + 1;
      if (frame_err) fe_cyc <= fe_cyc + 1;
      if (frame_err && !fe_d) fe_rise <= fe_rise + 1;
      busy_d <= busy;
      fe_d   <= frame_err;
   end

   logic [7:0] txb[$];
   int txs[$];
   logic txstop[$];
   int mon_st;
   logic [7:0] mon_b;
   initial forever begin
      @(negedge clk);
      if (!tx) begin
         mon_st = cyc;
         repeat (CPB / 2) @(negedge clk);
         for (int i = 0; i < 8; i++) begin
            repeat (CPB) @(negedge clk);
            mon_b[i] = tx;
         end
         repeat (CPB) @(negedge clk);
         txstop.push_back(tx);
         txb.push_back(mon_b);
         txs.push_back(mon_st);
      end
   end

   logic [7:0] acc[$];
   logic [15:0] exp_a[$];
   int exp_fe = 0, busy_until = -1, last_t = 0;
   int m_rd = 0, m_tx = 0, m_fe = 0, m_fec = 0, m_bf = 0, m_br = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic model_byte(input logic [7:0] b, input bit ok, input int t);
      logic [31:0] w;
      if (!ok) begin
         acc.delete();
         exp_fe++;
         return;
      end
      if (t <= busy_until) return;
`ifdef UART_RESP_TIMEOUT_EN
      if (acc.size() != 0 && (t - 10 * CPB) - last_t > TOB * CPB) acc.delete();
`endif
      acc.push_back(b);
      last_t = t;
      if (acc.size() == 4) begin
         w = {acc[3], acc[2], acc[1], acc[0]};
         exp_a.push_back(w[15:0]);
         busy_until = t + 3 + 40 * CPB;
         acc.delete();
      end
   endtask

   task automatic send_byte(input logic [7:0] b, input bit ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      rx = ok;
      repeat (CPB) @(negedge clk);
      rx = 1'b1;
      model_byte(b, ok, cyc - CPB / 2);
      repeat (2) @(negedge clk);
   endtask

   task automatic send_word(input logic [31:0] w, input int gap);
      for (int k = 0; k < 4; k++) begin
         send_byte(w[8*k +: 8], 1'b1);
         repeat (gap) @(negedge clk);
      end
   endtask

   task automatic mark();
      exp_a.delete();
      exp_fe = 0;
      m_rd = rd_a.size(); m_tx = txb.size(); m_fe = fe_rise; m_fec = fe_cyc;
      m_bf = bf_c.size(); m_br = b_rise;
   endtask

   task automatic settle();
      int quiet = 0, n = 0;
      while (quiet < 12 * CPB && n < 6000) begin
         @(negedge clk);
         n++;
         quiet = (busy || !tx) ? 0 : quiet + 1;
      end
      chk("settle within bound", int'(n < 6000), 1);
   endtask

   task automatic check_responses(input string tag);
      int n = exp_a.size();
      logic [31:0] d;
      chk({tag, " mem_rd pulses"}, rd_a.size() - m_rd, n);
      chk({tag, " tx byte count"}, txb.size() - m_tx, 4 * n);
      chk({tag, " frame_err pulses"}, fe_rise - m_fe, exp_fe);
      chk({tag, " frame_err cycles"}, fe_cyc - m_fec, exp_fe);
      if (rd_a.size() - m_rd == n && txb.size() - m_tx == 4 * n) begin
         for (int i = 0; i < n; i++) begin
            d = mem_f(exp_a[i]);
            chk({tag, " mem_addr"}, rd_a[m_rd + i], exp_a[i]);
            chk({tag, " start latency"}, txs[m_tx + 4*i] - rd_c[m_rd + i], 2);
            for (int k = 0; k < 4; k++) begin
               chk({tag, " tx byte"}, txb[m_tx + 4*i + k], d[8*k +: 8]);
               chk({tag, " tx stop"}, txstop[m_tx + 4*i + k], 1);
               if (k > 0) chk({tag, " byte spacing"}, txs[m_tx + 4*i + k] - txs[m_tx + 4*i + k - 1], 10 * CPB);
            end
         end
         if (n > 0)
            chk({tag, " busy fall"}, bf_c.size() > m_bf ? bf_c[bf_c.size()-1] - rd_c[rd_c.size()-1] : -1, 2 + 40 * CPB);
      end
      mark();
   endtask

   typedef struct { logic [31:0] word; logic [15:0] exp_addr; int gap; } vec_t;
   vec_t tbl[4];
   int n;

   initial begin
      tbl[0] = '{32'h0000_0004, 16'h0004, 0};
      tbl[1] = '{32'hFFFF_1234, 16'h1234, 0};
      tbl[2] = '{32'h5A5A_FFFF, 16'hFFFF, 25};
      tbl[3] = '{32'h0001_0000, 16'h0000, 7};
      repeat (4) @(negedge clk);
      chk("reset tx", tx, 1);
      chk("reset mem_rd", mem_rd, 0);
      chk("reset mem_addr", mem_addr, 0);
      chk("reset busy", busy, 0);
      chk("reset frame_err", frame_err, 0);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      mark();

      rx = 1'b0;
      repeat (CPB / 2 - 2) @(negedge clk);
      rx = 1'b1;
      settle();
      chk("glitch busy rises", b_rise - m_br, 0);
      check_responses("glitch");

      for (int i = 0; i < 4; i++) begin
         send_word(tbl[i].word, tbl[i].gap);
         settle();
         chk("table mem_addr", rd_a.size() > m_rd ? int'(rd_a[m_rd]) : -1, tbl[i].exp_addr);
         check_responses("table");
      end

      send_byte(8'h04, 1'b1);
      send_byte(8'h00, 1'b0);
      send_word(32'h0000_0004, 0);
      settle();
      check_responses("frame error");

      send_byte(8'h78, 1'b1);
      send_byte(8'h56, 1'b1);
      repeat (700) @(negedge clk);
      send_word(32'h0000_0004, 0);
      settle();
`ifdef UART_RESP_TIMEOUT_EN
      chk("stale mem_addr", rd_a.size() > m_rd ? int'(rd_a[m_rd]) : -1, 16'h0004);
`else
      chk("stale mem_addr", rd_a.size() > m_rd ? int'(rd_a[m_rd]) : -1, 16'h5678);
`endif
      check_responses("stale");

      send_word(32'h0000_0004, 0);
      n = 0;
      while (txb.size() <= m_tx && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("first response byte seen", int'(n < 3000), 1);
      repeat (60) @(negedge clk);
      chk("busy before reset", busy, 1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      chk("reset mid-response tx", tx, 1);
      chk("reset mid-response busy", busy, 0);
      chk("reset mid-response mem_rd", mem_rd, 0);
      @(negedge clk);
      reset = 1'b0;
      settle();
      acc.delete();
      busy_until = -1;
      mark();
      send_word(32'h0000_0004, 0);
      settle();
      check_responses("after reset");

      send_word(32'h0000_4321, 0);
      n = 0;
      while (busy && n < 3000) begin
         @(negedge clk);
         n++;
      end
      chk("busy falls", int'(n < 3000), 1);
      send_word(32'h0000_0004, 0);
      settle();
      check_responses("back to back");

      for (int i = 0; i < 10; i++) begin
         send_word($urandom, $urandom_range(0, 3 * CPB));
         settle();
         check_responses("random");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
